// File: rtl/cpu24_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu24_pkg
//  Purpose  : Shared constants and types for the 24-bit CPU fetch stage.
//             ADDR_W / DATA_W  - address and instruction word widths
//             RESET_PC         - PC value loaded on reset
//             PC_INC           - sequential increment (word-addressed memory)
//             fetch_state_t    - fetch FSM state encoding
//  Revision : 1.0  initial release
// ============================================================================
package cpu24_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 24;

  localparam logic [ADDR_W-1:0] RESET_PC = 24'h000000;
  localparam logic [ADDR_W-1:0] PC_INC   = 24'h000001;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_mux
//  Purpose  : Combinational next-PC priority select:
//             jump_target > branch_target > pc + PC_INC.
//  Ports    : pc             in   current program counter
//             jump           in   jump redirect request
//             jump_target    in   jump destination
//             branch_taken   in   taken-branch redirect request
//             branch_target  in   branch destination
//             pc_inc         out  pc + PC_INC (modulo 2^ADDR_W)
//             next_pc        out  selected next PC
//  Revision : 1.0  initial release
// ============================================================================
module pc_next_mux
  import cpu24_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] w_seq_or_branch;

  // Unsigned add wraps naturally at 2^ADDR_W; the carry is simply dropped.
  assign pc_inc = pc + PC_INC;

  // Two cascaded 2:1 selects: the jump stage sits last so it wins.
  assign w_seq_or_branch = branch_taken ? branch_target : pc_inc;
  assign next_pc         = jump ? jump_target : w_seq_or_branch;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Instruction fetch stage. Holds the PC, issues word fetches over
//             an imem req/ready handshake and presents one instruction at a
//             time to decode over a valid/ready handshake. Redirects (jump or
//             taken branch) squash in-flight work and insert one bubble.
//  Ports    : clk, rst              clock, synchronous active-high reset
//             jump, jump_target     unconditional redirect
//             branch_taken, branch_target  taken-branch redirect
//             imem_req, imem_addr   fetch request / address (= pc)
//             imem_ready, imem_rdata  memory accept + returned word
//             instr_valid, instr_ready  decode handshake
//             instr_out, pc_out, pc_plus_out  fetched word, its address, link
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit
  import cpu24_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus_out
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_mux_pc;
  logic              r_valid;
  logic              w_valid_next;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc_out;
  logic [ADDR_W-1:0] r_pc_plus;
  logic              w_redirect;
  logic              w_capture;

  pc_next_mux u_pc_next_mux (
    .pc            (r_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_inc        (w_pc_inc),
    .next_pc       (w_mux_pc)
  );

  assign w_redirect = jump | branch_taken;
  // A redirect in the same cycle squashes the returned word.
  assign w_capture  = (r_state == FETCH) && imem_ready && !w_redirect;

  // Next-state and next-register selection.
  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_pc_next    = r_pc;

    unique case (r_state)
      FETCH: begin
        if (w_capture) begin
          w_state_next = HOLD;
          w_valid_next = 1'b1;
          w_pc_next    = w_pc_inc;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          w_state_next = FETCH;
          w_valid_next = 1'b0;
        end
      end
      BUBBLE: begin
        w_state_next = FETCH;
      end
      default: begin
        w_state_next = FETCH;
        w_valid_next = 1'b0;
      end
    endcase

    // Redirect beats every state transition, including a decode accept.
    if (w_redirect) begin
      w_state_next = BUBBLE;
      w_valid_next = 1'b0;
      w_pc_next    = w_mux_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= '0;
      r_pc_out  <= RESET_PC;
      r_pc_plus <= RESET_PC + PC_INC;
    end else if (w_capture) begin
      r_instr   <= imem_rdata;
      r_pc_out  <= r_pc;
      r_pc_plus <= w_pc_inc;
    end
  end

  // The request is masked while reset is held so nothing is launched into
  // memory during a reset cycle; otherwise it depends only on state.
  assign imem_req    = (r_state == FETCH) && !rst;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign pc_plus_out = r_pc_plus;

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction fetch stage of the 24-bit CPU. Holds the program counter and issues word fetches to instruction memory over a req/ready handshake.
- Presents one fetched instruction at a time to decode over a valid/ready handshake.
- Computes next-PC by priority selection: jump target > branch target > PC+PC_INC.
- Its outputs pc_plus_out and instr_out feed the downstream operand/write-back select muxes.

Parameters:
ADDR_W, 24, PC and instruction-memory address width
DATA_W, 24, instruction word width
RESET_PC, 24'h000000, PC value loaded on reset
PC_INC, 1, sequential PC increment (memory is word-addressed)

Ports:
Clock  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
jump  input  1  unconditional redirect request (one-cycle pulse)
jump_target  input  ADDR_W  jump destination
branch_taken  input  1  taken-branch redirect request (one-cycle pulse)
branch_target  input  ADDR_W  branch destination
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address; equals the current PC
imem_ready  input  1  memory accepts the request and returns imem_rdata this cycle
imem_rdata  input  DATA_W  fetched word; valid only when imem_req && imem_ready
instr_valid  output  1  instr_out/pc_out hold a valid instruction
instr_ready  input  1  decode accepts the instruction
instr_out  output  DATA_W  fetched instruction
pc_out  output  ADDR_W  address of instr_out
pc_plus_out  output  ADDR_W  pc_out+PC_INC (link value)

Behaviour:
- Reset (Clock edge with Reset=1): pc=RESET_PC, state=FETCH, instr_valid=0, instr_out=0, pc_out=RESET_PC, pc_plus_out=RESET_PC+PC_INC.
  - imem_req is low on the cycle Reset is asserted and goes high on the first cycle after Reset deasserts.
  - Reset overrides every other input. Any in-flight request is abandoned with no data captured.
- States: FETCH, HOLD, BUBBLE.
- imem_req=1 only in FETCH. imem_addr=pc at all times. The PC is stable while imem_req=1 (no change until handshake or redirect).
- FETCH:
  - imem_req=1.
  - On imem_ready: capture instr_out<=imem_rdata, pc_out<=pc, pc_plus_out<=pc+PC_INC, pc<=pc+PC_INC, instr_valid<=1, go HOLD.
  - Minimum latency: req and ready in cycle N gives instr_valid=1 in cycle N+1.
- HOLD:
  - instr_valid=1; outputs held stable until accepted.
  - On instr_ready: instr_valid<=0, go FETCH.
  - Peak throughput is one instruction per 2 cycles.
- Redirect (jump | branch_taken), any state:
  - Target = jump ? jump_target : branch_target. Jump wins if both are asserted.
  - Actions: pc<=target, instr_valid<=0, go BUBBLE.
  - Redirect squashes:
    - memory data returned in the same cycle (imem_ready ignored, PC not incremented);
    - the held instruction, even if instr_ready=1 in the same cycle.
- BUBBLE: imem_req=0 for exactly one cycle, then FETCH. A new redirect during BUBBLE reloads pc and stays in BUBBLE one more cycle.
- Arithmetic: all PC math is unsigned modulo 2^ADDR_W. 24'hFFFFFF+1 wraps to 24'h000000 with no flag.
- No combinational path from instr_ready or imem_ready to any output except through registered state. imem_req/imem_addr depend only on state and pc.

Decomposition:
- Shared package cpu24_pkg:
  - ADDR_W, DATA_W, RESET_PC, PC_INC constants.
  - fetch_state_t enum {FETCH, HOLD, BUBBLE}.
- One sub-module, pc_next_mux: combinational 3-way priority select of jump_target / branch_target / pc+PC_INC, built from two 2:1 selects. It is instantiated once. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release, imem_ready tied 1, instr_ready tied 1, memory returns addr+24'h100000.
  - Required: imem_addr sequence 0,1,2,3 on alternate cycles.
  - Required: instr_out 24'h100000, 24'h100001, … with pc_out 0,1,2 and pc_plus_out 1,2,3.
- imem_ready low 3 cycles in FETCH at pc=5.
  - Required: imem_req=1 and imem_addr=5 stable all 3 cycles.
  - Required: instr_valid rises the cycle after ready; PC becomes 6.
- instr_valid=1 with instr_out=24'hABCDEF, instr_ready low 4 cycles.
  - Required: outputs stable, no imem_req.
  - Required: on ready, instr_valid drops and the next fetch starts.
- jump=1 (target 24'h000040) and branch_taken=1 (target 24'h000080) in the same cycle, while in HOLD with instr_ready=1.
  - Required: instruction squashed, one BUBBLE cycle with imem_req=0, then imem_addr=24'h000040.
- Start at pc=24'hFFFFFF, fetch completes.
  - Required: pc_plus_out=24'h000000 and the next imem_addr=24'h000000.
- Reset asserted in FETCH while imem_ready=1.
  - Required: no capture (instr_valid=0), pc=RESET_PC on the next cycle, fetch restarts at 0.
